// File: rtl/pe_rx_monitor.sv
// pe_rx_monitor: receive-side endpoint of the router-to-PE local link.
// Sinks flits from the router local output and checks each flit's destination.
// Counts correctly routed packets and collects min/max/sum latency statistics.
// Raises the finish flag once the expected packet count for the task has arrived.
module pe_rx_monitor #(
    parameter logic [2:0] MY_ID      = 3'd0,
    parameter int         DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable_wire,
    input  logic                  flush_wire,
    input  logic [2:0]            receive_num_wire,
    input  logic [7:0]            time_now,
    input  logic [DATA_WIDTH-1:0] data_r2p,
    input  logic                  valid_r2p,
    output logic                  task_receive_finish_flag,
    output logic [7:0]            rx_count,
    output logic [7:0]            misroute_count,
    output logic [7:0]            src_seen,
    output logic [7:0]            latency_min,
    output logic [7:0]            latency_max,
    output logic [26:0]           latency_sum,
    output logic                  rx_overrun
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]            state;
    logic [1:0]            state_nx;

    logic [DATA_WIDTH-1:0] s0_data;
    logic                  s0_valid;
    logic [7:0]            s0_time;

    logic [2:0]            flit_src;
    logic [2:0]            flit_dst;
    logic [7:0]            lat;
    logic [27:0]           sum_ext;
    logic                  unused_payload;

    logic [7:0]            rx_nx;
    logic [7:0]            mis_nx;
    logic [7:0]            src_nx;
    logic [7:0]            min_nx;
    logic [7:0]            max_nx;
    logic [26:0]           sum_nx;
    logic                  ovr_nx;

    // Header fields and wrap-around latency of the flit held in stage 0.
    assign flit_src       = s0_data[31:29];
    assign flit_dst       = s0_data[28:26];
    assign lat            = s0_time - s0_data[25:18];
    assign sum_ext        = {1'b0, latency_sum} + {20'd0, lat};
    assign unused_payload = ^s0_data[17:0];

    // Stage 0: capture the link and timestamp every cycle; flush drops an in-flight flit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_data  <= '0;
            s0_valid <= 1'b0;
            s0_time  <= 8'd0;
        end else begin
            s0_data  <= data_r2p;
            s0_time  <= time_now;
            s0_valid <= flush_wire ? 1'b0 : valid_r2p;
        end
    end

    // Stage-1 next-state: statistics update first, then FSM decides on the updated count.
    always_comb begin
        state_nx = state;
        rx_nx    = rx_count;
        mis_nx   = misroute_count;
        src_nx   = src_seen;
        min_nx   = latency_min;
        max_nx   = latency_max;
        sum_nx   = latency_sum;
        ovr_nx   = rx_overrun;
        case (state)
            ST_IDLE: begin
                if (enable_wire) begin
                    state_nx = (receive_num_wire == 3'd0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (s0_valid) begin
                    if (flit_dst == MY_ID) begin
                        if (rx_count != 8'hFF) begin
                            rx_nx = rx_count + 8'd1;
                        end
                        src_nx = src_seen | (8'd1 << flit_src);
                        if (lat < latency_min) begin
                            min_nx = lat;
                        end
                        if (lat > latency_max) begin
                            max_nx = lat;
                        end
                        sum_nx = sum_ext[27] ? {27{1'b1}} : sum_ext[26:0];
                    end else if (misroute_count != 8'hFF) begin
                        mis_nx = misroute_count + 8'd1;
                    end
                end
                if (rx_nx == {5'd0, receive_num_wire}) begin
                    state_nx = ST_DONE;
                end else if (!enable_wire) begin
                    state_nx = ST_IDLE;
                end
            end
            ST_DONE: begin
                if (s0_valid) begin
                    ovr_nx = 1'b1;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // Stage 1: commit statistics and state; flush overrides any concurrent update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                    <= ST_IDLE;
            rx_count                 <= 8'd0;
            misroute_count           <= 8'd0;
            src_seen                 <= 8'd0;
            latency_min              <= 8'hFF;
            latency_max              <= 8'd0;
            latency_sum              <= 27'd0;
            rx_overrun               <= 1'b0;
            task_receive_finish_flag <= 1'b0;
        end else if (flush_wire) begin
            state                    <= ST_IDLE;
            rx_count                 <= 8'd0;
            misroute_count           <= 8'd0;
            src_seen                 <= 8'd0;
            latency_min              <= 8'hFF;
            latency_max              <= 8'd0;
            latency_sum              <= 27'd0;
            rx_overrun               <= 1'b0;
            task_receive_finish_flag <= 1'b0;
        end else begin
            state                    <= state_nx;
            rx_count                 <= rx_nx;
            misroute_count           <= mis_nx;
            src_seen                 <= src_nx;
            latency_min              <= min_nx;
            latency_max              <= max_nx;
            latency_sum              <= sum_nx;
            rx_overrun               <= ovr_nx;
            task_receive_finish_flag <= (state_nx == ST_DONE);
        end
    end

endmodule
